// File: rtl/jedro_1_mem_arbiter.sv
// Arbiter that shares one single-port RAM between the instruction fetch port and the data (LSU) port.
// Grants are combinational and round-robin, and each granted access returns its response one cycle later.
module jedro_1_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  input  logic                    i_flush_i,
  output logic                    i_gnt_o,
  output logic                    i_rvalid_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_INSTR   = 2'd1,
    OWN_DATA_RD = 2'd2,
    OWN_DATA_WR = 2'd3
  } owner_e;

  owner_e owner_q, owner_d;
  logic   last_d_q, last_d_d;  // 1: the data port holds the most recent grant
  logic   i_cand, d_cand;
  logic   i_win, d_win;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q  <= OWN_NONE;
      last_d_q <= 1'b1;
    end else begin
      owner_q  <= owner_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    owner_d     = OWN_NONE;
    last_d_d    = last_d_q;
    i_gnt_o     = 1'b0;
    d_gnt_o     = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    i_rvalid_o  = 1'b0;
    i_rdata_o   = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;

    // A flush blocks the fetch port, and reset silences both ports at once.
    i_cand = i_req_i & ~i_flush_i & ~rst_i;
    d_cand = d_req_i & ~rst_i;
    if (i_cand && d_cand) begin
      i_win = last_d_q;
      d_win = ~last_d_q;
    end else begin
      i_win = i_cand;
      d_win = d_cand;
    end

    if (i_win) begin
      i_gnt_o    = 1'b1;
      mem_en_o   = 1'b1;
      mem_addr_o = i_addr_i;
      owner_d    = OWN_INSTR;
      last_d_d   = 1'b0;
    end else if (d_win) begin
      d_gnt_o     = 1'b1;
      mem_en_o    = 1'b1;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_we_o    = d_we_i ? d_be_i : '0;
      owner_d     = d_we_i ? OWN_DATA_WR : OWN_DATA_RD;
      last_d_d    = 1'b1;
    end else begin
      owner_d = OWN_NONE;
    end

    case (owner_q)
      OWN_INSTR: begin
        if (!i_flush_i && !rst_i) begin
          i_rvalid_o = 1'b1;
          i_rdata_o  = mem_rdata_i;
        end else begin
          i_rvalid_o = 1'b0;
        end
      end
      OWN_DATA_RD: begin
        d_rvalid_o = ~rst_i;
        d_rdata_o  = rst_i ? '0 : mem_rdata_i;
      end
      OWN_DATA_WR: begin
        d_rvalid_o = ~rst_i;
      end
      default: begin
        i_rvalid_o = 1'b0;
        d_rvalid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Randomized bench for jedro_1_mem_arbiter: a transaction-level model is checked on every falling edge,
// alongside directed scenarios that carry hand-computed literal expectations.
module tb_jedro_1_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          i_req_i, i_flush_i, d_req_i, d_we_i;
  logic [AW-1:0] i_addr_i, d_addr_i;
  logic [3:0]    d_be_i;
  logic [DW-1:0] d_wdata_i, mem_rdata_i;
  logic          i_gnt_o, i_rvalid_o, d_gnt_o, d_rvalid_o, mem_en_o;
  logic [DW-1:0] i_rdata_o, d_rdata_o, mem_wdata_o;
  logic [3:0]    mem_we_o;
  logic [AW-1:0] mem_addr_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  jedro_1_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_flush_i(i_flush_i),
    .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the pending response is a single tagged transaction.
  // Tags: 0 = none, 1 = fetch, 2 = data read, 3 = data write.
  int m_pend   = 0;
  bit m_last_d = 1'b1;

  always @(negedge clk_i) begin
    bit            e_ig, e_dg, iw, dw;
    logic [AW-1:0] e_addr;
    if (rst_i) begin
      chk("rst_i_gnt", i_gnt_o, 0);      chk("rst_d_gnt", d_gnt_o, 0);
      chk("rst_i_rvalid", i_rvalid_o, 0); chk("rst_d_rvalid", d_rvalid_o, 0);
      chk("rst_i_rdata", i_rdata_o, 0);   chk("rst_d_rdata", d_rdata_o, 0);
      chk("rst_mem_en", mem_en_o, 0);     chk("rst_mem_we", mem_we_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0); chk("rst_mem_wdata", mem_wdata_o, 0);
      m_pend   = 0;
      m_last_d = 1'b1;
    end else begin
      iw = i_req_i && !i_flush_i;
      dw = d_req_i;
      if (iw && dw) begin
        e_ig = m_last_d;
        e_dg = !m_last_d;
      end else begin
        e_ig = iw;
        e_dg = dw;
      end
      e_addr = e_ig ? i_addr_i : (e_dg ? d_addr_i : '0);
      chk("i_gnt", i_gnt_o, e_ig);
      chk("d_gnt", d_gnt_o, e_dg);
      chk("mem_en", mem_en_o, e_ig || e_dg);
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_we", mem_we_o, (e_dg && d_we_i) ? d_be_i : 4'h0);
      chk("mem_wdata", mem_wdata_o, e_dg ? d_wdata_i : 32'h0);
      chk("i_rvalid", i_rvalid_o, (m_pend == 1) && !i_flush_i);
      chk("i_rdata", i_rdata_o, ((m_pend == 1) && !i_flush_i) ? mem_rdata_i : 32'h0);
      chk("d_rvalid", d_rvalid_o, m_pend >= 2);
      chk("d_rdata", d_rdata_o, (m_pend == 2) ? mem_rdata_i : 32'h0);
      m_pend = e_ig ? 1 : (e_dg ? (d_we_i ? 3 : 2) : 0);
      if (e_ig) m_last_d = 1'b0;
      if (e_dg) m_last_d = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
    mem_rdata_i = $urandom;
  endtask

  task automatic idle();
    i_req_i = 1'b0; i_flush_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    i_addr_i = '0; d_addr_i = '0; d_be_i = 4'h0; d_wdata_i = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    mem_rdata_i = '0;
    idle();
    repeat (2) step();
    rst_i = 1'b0;

    // Single fetch, then its response one cycle later.
    step(); i_req_i = 1'b1; i_addr_i = 32'h100;
    #1; chk("t38_gnt", i_gnt_o, 1); chk("t38_addr", mem_addr_o, 32'h100);
    step(); idle(); mem_rdata_i = 32'hCAFE0001;
    #1; chk("t38_rvalid", i_rvalid_o, 1); chk("t38_rdata", i_rdata_o, 32'hCAFE0001);

    // Fresh reset, then both ports request continuously: I,D,I,D.
    step(); rst_i = 1'b1;
    step(); rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); i_req_i = 1'b1; d_req_i = 1'b1; i_addr_i = 32'h200 + k; d_addr_i = 32'h300 + k;
      #1;
      chk("t39_i_gnt", i_gnt_o, (k % 2) == 0);
      chk("t39_d_gnt", d_gnt_o, (k % 2) == 1);
      chk("t39_i_rv", i_rvalid_o, (k % 2) == 1);
      chk("t39_d_rv", d_rvalid_o, (k >= 2) && ((k % 2) == 0));
    end
    step(); idle();
    #1; chk("t39_d_rv_last", d_rvalid_o, 1); chk("t39_i_rv_last", i_rvalid_o, 0);

    // Partial write, then its acknowledge with zero read data.
    step(); d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_wdata_i = 32'hDEADBEEF; d_addr_i = 32'h40;
    #1; chk("t40_we", mem_we_o, 4'b0011); chk("t40_wdata", mem_wdata_o, 32'hDEADBEEF);
    step(); idle(); mem_rdata_i = 32'h12345678;
    #1; chk("t40_rv", d_rvalid_o, 1); chk("t40_rdata", d_rdata_o, 0);

    // Fetch granted, then flushed in the next cycle while data requests.
    step(); i_req_i = 1'b1; i_addr_i = 32'h500;
    #1; chk("t41_i_gnt", i_gnt_o, 1);
    step(); i_flush_i = 1'b1; d_req_i = 1'b1; d_addr_i = 32'h600;
    #1; chk("t41_i_rv", i_rvalid_o, 0); chk("t41_d_gnt", d_gnt_o, 1); chk("t41_i_gnt2", i_gnt_o, 0);

    // Reset asserted mid-cycle while a data read response is outstanding.
    step(); idle(); d_req_i = 1'b1; d_addr_i = 32'h700;
    step(); idle();
    #1; chk("t42_rv_before", d_rvalid_o, 1);
    #1; rst_i = 1'b1;
    #1; chk("t42_rv_rst", d_rvalid_o, 0); chk("t42_en_rst", mem_en_o, 0);
    step(); rst_i = 1'b0;
    #1; chk("t42_rv_after", d_rvalid_o, 0);

    // Three idle cycles.
    for (int k = 0; k < 3; k++) begin
      step(); idle();
      #1;
      chk("t43_en", mem_en_o, 0); chk("t43_we", mem_we_o, 0);
      chk("t43_irv", i_rvalid_o, 0); chk("t43_drv", d_rvalid_o, 0);
    end

    // Random traffic with occasional resets, checked by the model.
    for (int k = 0; k < 600; k++) begin
      step();
      rst_i     = ($urandom_range(63) == 0);
      i_req_i   = $urandom_range(1);
      i_flush_i = ($urandom_range(4) == 0);
      d_req_i   = $urandom_range(1);
      d_we_i    = $urandom_range(1);
      d_be_i    = 4'($urandom);
      i_addr_i  = $urandom;
      d_addr_i  = $urandom;
      d_wdata_i = $urandom;
    end
    step(); idle(); rst_i = 1'b0;
    step();
    @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jedro_1_mem_arbiter.md
JEDRO_1_MEM_ARBITER -- requirements
Module: jedro_1_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, the byte address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the memory word width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: clk_i  input  1  rising-edge clock.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 i_req_i  input  1  instruction fetch read request.
REQ-006 i_addr_i  input  ADDR_WIDTH  instruction fetch address.
REQ-007 i_flush_i  input  1  discard any outstanding instruction response (jump taken).
REQ-008 i_gnt_o  output  1  instruction request accepted this cycle.
REQ-009 i_rvalid_o  output  1  instruction read data valid.
REQ-010 i_rdata_o  output  DATA_WIDTH  instruction read data.
REQ-011 d_req_i  input  1  data (LSU) request.
REQ-012 d_we_i  input  1  data write enable (1 = write, 0 = read).
REQ-013 d_be_i  input  DATA_WIDTH/8  data byte enables.
REQ-014 d_addr_i  input  ADDR_WIDTH  data address.
REQ-015 d_wdata_i  input  DATA_WIDTH  data write data.
REQ-016 d_gnt_o  output  1  data request accepted this cycle.
REQ-017 d_rvalid_o  output  1  data response valid (read data or write acknowledge).
REQ-018 d_rdata_o  output  DATA_WIDTH  data read data.
REQ-019 mem_en_o  output  1  shared single-port RAM access enable.
REQ-020 mem_we_o  output  DATA_WIDTH/8  RAM per-byte write enables.
REQ-021 mem_addr_o  output  ADDR_WIDTH  RAM address.
REQ-022 mem_wdata_o  output  DATA_WIDTH  RAM write data.
REQ-023 mem_rdata_i  input  DATA_WIDTH  RAM read data, valid exactly one cycle after mem_en_o.

Function
REQ-024 Grant SHALL be combinational, same cycle as the request; at most one of i_gnt_o/d_gnt_o SHALL be 1 in any cycle.
REQ-025 Only one requester active -> that requester SHALL be granted; neither -> no grant, mem_en_o=0.
REQ-026 Both active -> round-robin: the requester NOT granted most recently SHALL win; last_grant register resets to DATA, so instruction wins the first conflict.
REQ-027 last_grant SHALL update only on a cycle with a grant.
REQ-028 Granted cycle: mem_en_o=1, mem_addr_o=winner address; instruction grant -> mem_we_o=0; data grant -> mem_we_o = d_we_i ? d_be_i : 0, mem_wdata_o=d_wdata_i.
REQ-029 Non-granted cycles: mem_we_o=0, mem_addr_o and mem_wdata_o = 0.
REQ-030 Response owner register SHALL take states NONE, INSTR, DATA_RD, DATA_WR; next state = winner of current cycle (NONE if no grant).
REQ-031 Owner INSTR -> i_rvalid_o=1, i_rdata_o=mem_rdata_i; DATA_RD -> d_rvalid_o=1, d_rdata_o=mem_rdata_i; DATA_WR -> d_rvalid_o=1, d_rdata_o=0.
REQ-032 rdata outputs SHALL be 0 when their rvalid is 0.
REQ-033 Latency SHALL be exactly 1 cycle grant-to-rvalid; back-to-back grants every cycle SHALL be supported with no bubble.
REQ-034 i_flush_i=1 SHALL suppress i_rvalid_o in the same cycle if owner is INSTR, and SHALL block an instruction grant that cycle (data may still be granted).
REQ-035 i_flush_i SHALL NOT affect data responses.

Reset
REQ-036 While rst_i=1: all outputs 0, owner=NONE, last_grant=DATA, regardless of clock.
REQ-037 Reset asserted with a response outstanding SHALL drop it; no rvalid SHALL appear after reset release for pre-reset grants.

Verification
REQ-038 i_req_i=1, i_addr_i=0x100, d_req_i=0 -> i_gnt_o=1, mem_addr_o=0x100 same cycle; next cycle i_rvalid_o=1, i_rdata_o=mem_rdata_i.
REQ-039 Both request continuously for 4 cycles after reset -> grants I,D,I,D; rvalids follow one cycle later in same order.
REQ-040 d_req_i=1, d_we_i=1, d_be_i=4'b0011, d_wdata_i=0xDEADBEEF -> mem_we_o=4'b0011, mem_wdata_o=0xDEADBEEF; next cycle d_rvalid_o=1, d_rdata_o=0.
REQ-041 Instruction granted cycle N, i_flush_i=1 in N+1 with d_req_i=1 -> i_rvalid_o=0 in N+1, d_gnt_o=1 in N+1.
REQ-042 rst_i asserted mid-cycle after a data read grant -> all outputs 0 immediately; after release no d_rvalid_o.
REQ-043 No requests for 3 cycles -> mem_en_o=0, mem_we_o=0, both rvalids 0 throughout.
